// File: rtl/hog_svm_pkg.sv
// Shared types and constants for the HOG/SVM frame controller.
package hog_svm_pkg;

    localparam int FEA_W_DEF = 32;
    localparam int N_BIN     = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/hit_fifo.sv
// First-word fall-through FIFO for detected window ids; pointers carry one
// extra wrap bit so full and empty are distinguished without a counter.
module hit_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // A pop frees the slot in the same cycle, so a push into a full FIFO still lands.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/svm_frame_ctrl.sv
// Frame sequencer between the HOG block stream and the SVM: forwards N_BLK
// feature blocks, collects N_SW window results and queues detected windows.
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_RUN   | accepting feature blocks, counting results
//   ST_DRAIN | all blocks sent, waiting for remaining results (bounded)
//   ST_DONE  | one-cycle done pulse
module svm_frame_ctrl
    import hog_svm_pkg::*;
#(
    parameter int FEA_W     = FEA_W_DEF,
    parameter int N_BLK     = 4000,
    parameter int N_SW      = 3780,
    parameter int SW_ID_W   = 16,
    parameter int HIT_DEPTH = 8,
    parameter int DRAIN_TO  = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    input  logic [N_BIN*FEA_W-1:0]   s_fea_a,
    input  logic [N_BIN*FEA_W-1:0]   s_fea_b,
    input  logic [N_BIN*FEA_W-1:0]   s_fea_c,
    input  logic [N_BIN*FEA_W-1:0]   s_fea_d,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [N_BIN*FEA_W-1:0]   m_fea_a,
    output logic [N_BIN*FEA_W-1:0]   m_fea_b,
    output logic [N_BIN*FEA_W-1:0]   m_fea_c,
    output logic [N_BIN*FEA_W-1:0]   m_fea_d,
    output logic                     m_valid,
    input  logic                     svm_is_person,
    input  logic                     svm_o_valid,
    input  logic [SW_ID_W-1:0]       svm_sw_id,
    output logic [SW_ID_W-1:0]       hit_id,
    output logic                     hit_valid,
    input  logic                     hit_ready,
    output logic [SW_ID_W-1:0]       hit_cnt,
    output logic                     overflow,
    output logic                     timeout_err
);

    localparam int BW = $clog2(N_BLK + 1);
    localparam int RW = $clog2(N_SW + 1);
    localparam int TW = $clog2(DRAIN_TO + 1);

    state_t          state;
    state_t          state_nxt;
    logic [BW-1:0]   blk_cnt;
    logic [RW-1:0]   res_cnt;
    logic [TW-1:0]   drain_tmr;
    logic            xfer;
    logic            counting;
    logic            res_ev;
    logic            hit_ev;
    logic            last_blk;
    logic            res_full;
    logic            drain_exp;
    logic            fifo_empty;
    logic            fifo_full;
    logic            fifo_pop;
    logic            frame_start;

    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign s_ready     = (state == ST_RUN);
    assign xfer        = s_valid & s_ready;
    assign counting    = (state == ST_RUN) || (state == ST_DRAIN);
    assign res_ev      = svm_o_valid & counting;
    assign hit_ev      = res_ev & svm_is_person;
    assign last_blk    = xfer && (blk_cnt == BW'(N_BLK - 1));
    // Include this cycle's result so done follows the final result by one cycle.
    assign res_full    = (int'(res_cnt) + int'(res_ev)) >= N_SW;
    assign drain_exp   = (drain_tmr == '0);
    assign frame_start = (state == ST_IDLE) && start;
    assign hit_valid   = ~fifo_empty;
    assign fifo_pop    = hit_valid & hit_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN:   if (last_blk) state_nxt = ST_DRAIN;
            ST_DRAIN: if (res_full || drain_exp) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blk_cnt     <= '0;
            res_cnt     <= '0;
            drain_tmr   <= '0;
            hit_cnt     <= '0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else if (frame_start) begin
            blk_cnt     <= '0;
            res_cnt     <= '0;
            hit_cnt     <= '0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (xfer) blk_cnt <= blk_cnt + BW'(1);
            if (res_ev && (res_cnt != RW'(N_SW))) res_cnt <= res_cnt + RW'(1);
            if (hit_ev && (hit_cnt != '1)) hit_cnt <= hit_cnt + SW_ID_W'(1);
            if (hit_ev && fifo_full && !fifo_pop) overflow <= 1'b1;
            if (last_blk)
                drain_tmr <= TW'(DRAIN_TO - 1);
            else if ((state == ST_DRAIN) && !drain_exp)
                drain_tmr <= drain_tmr - TW'(1);
            if ((state == ST_DRAIN) && !res_full && drain_exp) timeout_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_fea_a <= '0;
            m_fea_b <= '0;
            m_fea_c <= '0;
            m_fea_d <= '0;
        end else begin
            m_valid <= xfer;
            if (xfer) begin
                m_fea_a <= s_fea_a;
                m_fea_b <= s_fea_b;
                m_fea_c <= s_fea_c;
                m_fea_d <= s_fea_d;
            end
        end
    end

    hit_fifo #(
        .WIDTH (SW_ID_W),
        .DEPTH (HIT_DEPTH)
    ) u_hit_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (hit_ev),
        .push_data (svm_sw_id),
        .pop       (fifo_pop),
        .head      (hit_id),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule
